// File: rtl/fft_pingpong_ram.sv
// Ping-pong complex sample buffer for an in-place radix-2 FFT.
// Two banks share one storage array: the bank bit is the top address bit.
// The read bank is bank_sel and the write bank is ~bank_sel, so a read and a
// write in the same cycle never touch the same bank. A swap exchanges the two
// roles and advances the stage counter; the last swap of a transform wraps
// the counter and pulses done.
module fft_pingpong_ram #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9,
    parameter int STAGES    = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [N-1:0]                 add_a,
    input  logic [N-1:0]                 add_b,
    input  logic [BIT_WIDTH-1:0]         real_din_a,
    input  logic [BIT_WIDTH-1:0]         img_din_a,
    input  logic [BIT_WIDTH-1:0]         real_din_b,
    input  logic [BIT_WIDTH-1:0]         img_din_b,
    input  logic                         re,
    input  logic [N-1:0]                 rd_add_a,
    input  logic [N-1:0]                 rd_add_b,
    input  logic                         swap,
    output logic [2*BIT_WIDTH-1:0]       dout_a,
    output logic [2*BIT_WIDTH-1:0]       dout_b,
    output logic                         dout_valid,
    output logic                         bank_sel,
    output logic [$clog2(STAGES+1)-1:0]  stage,
    output logic                         done,
    output logic                         collision
);

    localparam int W     = 2 * BIT_WIDTH;
    localparam int DEPTH = 2 ** N;
    localparam int SW    = $clog2(STAGES + 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(STAGES - 1);

    // Both banks in one array; index = {bank, address}. Not reset.
    logic [W-1:0] mem [0:2*DEPTH-1];

    logic [W-1:0]  dout_a_q, dout_a_d;
    logic [W-1:0]  dout_b_q, dout_b_d;
    logic          dout_valid_q, dout_valid_d;
    logic          bank_sel_q, bank_sel_d;
    logic [SW-1:0] stage_q, stage_d;
    logic          done_q, done_d;
    logic          collision_q, collision_d;

    logic [N:0]    wr_addr_a, wr_addr_b;
    logic [N:0]    rd_addr_a, rd_addr_b;
    logic [W-1:0]  wr_word_a, wr_word_b;

    // Address mapping: reads use the current bank, writes the other one.
    always_comb begin
        wr_addr_a = {~bank_sel_q, add_a};
        wr_addr_b = {~bank_sel_q, add_b};
        rd_addr_a = {bank_sel_q, rd_add_a};
        rd_addr_b = {bank_sel_q, rd_add_b};
        wr_word_a = {real_din_a, img_din_a};
        wr_word_b = {real_din_b, img_din_b};
    end

    // Storage writes; port B is written last so it wins on an address clash.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr_a] <= wr_word_a;
            mem[wr_addr_b] <= wr_word_b;
        end
    end

    // Next-state logic for read registers, flags, bank select and stage counter.
    always_comb begin
        dout_a_d     = dout_a_q;
        dout_b_d     = dout_b_q;
        dout_valid_d = re;
        collision_d  = we && (add_a == add_b);
        bank_sel_d   = bank_sel_q ^ swap;
        stage_d      = stage_q;
        done_d       = 1'b0;
        if (re) begin
            dout_a_d = mem[rd_addr_a];
            dout_b_d = mem[rd_addr_b];
        end
        if (swap) begin
            if (stage_q == STAGE_LAST) begin
                stage_d = '0;
                done_d  = 1'b1;
            end else begin
                stage_d = stage_q + 1'b1;
            end
        end
    end

    // State registers; reset abandons any transform and discards in-flight reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_a_q     <= '0;
            dout_b_q     <= '0;
            dout_valid_q <= 1'b0;
            bank_sel_q   <= 1'b0;
            stage_q      <= '0;
            done_q       <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            dout_a_q     <= dout_a_d;
            dout_b_q     <= dout_b_d;
            dout_valid_q <= dout_valid_d;
            bank_sel_q   <= bank_sel_d;
            stage_q      <= stage_d;
            done_q       <= done_d;
            collision_q  <= collision_d;
        end
    end

    assign dout_a     = dout_a_q;
    assign dout_b     = dout_b_q;
    assign dout_valid = dout_valid_q;
    assign bank_sel   = bank_sel_q;
    assign stage      = stage_q;
    assign done       = done_q;
    assign collision  = collision_q;

endmodule
